// File: rtl/gpio_port_mux.sv
// gpio_port_mux: routes HostMot2 I/O onto expansion headers in STRAIGHT or DB25 layout,
// with guarded mode switching and LED pulse stretching. Define GPIO_INPUT_FILTER_EN for an input glitch filter.
module gpio_port_mux #(
  parameter int NUM_GPIO       = 2,
  parameter int GPIO_WIDTH     = 36,
  parameter int PORT_WIDTH     = 17,
  parameter int PORTS_PER_GPIO = 2,
  parameter int LED_COUNT      = 4,
  parameter int GUARD_CYCLES   = 16,
  parameter int STRETCH_CYCLES = 50000,
  localparam int IOW = NUM_GPIO * PORTS_PER_GPIO * PORT_WIDTH,
  localparam int GW  = NUM_GPIO * GPIO_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IOW-1:0]       io_out,
  input  logic [IOW-1:0]       io_oe,
  output logic [IOW-1:0]       io_in,
  input  logic [LED_COUNT-1:0] led_in,
  output logic [LED_COUNT-1:0] led_out,
  input  logic                 mode_wr,
  input  logic [NUM_GPIO-1:0]  mode_req,
  output logic [NUM_GPIO-1:0]  mode_cur,
  output logic                 mode_busy,
  output logic [GW-1:0]        gpio_out,
  output logic [GW-1:0]        gpio_oe,
  input  logic [GW-1:0]        gpio_in
);

  localparam int PPW   = PORTS_PER_GPIO * PORT_WIDTH;
  localparam int LPG   = LED_COUNT / NUM_GPIO;
  localparam int SPW   = GPIO_WIDTH - PPW;
  localparam int GCW   = $clog2(GUARD_CYCLES + 1);
  localparam int SCW   = $clog2(STRETCH_CYCLES + 1);
  localparam logic [GCW-1:0] GUARD_LAST   = GCW'(GUARD_CYCLES - 1);
  localparam logic [SCW-1:0] STRETCH_LOAD = SCW'(STRETCH_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_APPLY} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [GCW-1:0]        r_guard_cnt;
  logic [NUM_GPIO-1:0]   r_pending;
  logic [NUM_GPIO-1:0]   r_mode_cur;
  logic [NUM_GPIO-1:0]   w_mode_next;
  logic                  w_busy;
  logic                  w_load_guard;
  logic                  w_oe_allowed;
  logic [GW-1:0]         w_map_out;
  logic [GW-1:0]         w_map_oe;
  logic [GW-1:0]         r_gpio_out;
  logic [GW-1:0]         r_gpio_oe;
  logic [GW-1:0]         r_sync1;
  logic [GW-1:0]         r_sync2;
  logic [GW-1:0]         w_in_clean;
  logic [IOW-1:0]        w_io_map;
  logic [NUM_GPIO*SPW-1:0] w_unused_pins;
  logic [LED_COUNT-1:0]  r_led_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // A write during GUARD keeps us guarding so the counter can restart.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (mode_wr && (mode_req != r_mode_cur)) w_state_next = S_GUARD;
      S_GUARD: if (!mode_wr && (r_guard_cnt == GUARD_LAST)) w_state_next = S_APPLY;
      S_APPLY: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_load_guard = ((r_state == S_IDLE) && (w_state_next == S_GUARD)) ||
                   ((r_state == S_GUARD) && mode_wr);
    w_mode_next  = (r_state == S_APPLY) ? r_pending : r_mode_cur;
    w_oe_allowed = (w_state_next == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_guard_cnt <= '0;
      r_pending   <= '0;
      r_mode_cur  <= '0;
    end else begin
      if (w_load_guard) begin
        r_guard_cnt <= '0;
        r_pending   <= mode_req;
      end else if (r_state == S_GUARD) begin
        r_guard_cnt <= r_guard_cnt + 1'b1;
      end
      if (r_state == S_APPLY) r_mode_cur <= r_pending;
    end
  end

  // Output mapping uses the mode that will be in force after this edge.
  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_hdr
    for (genvar k = 0; k < PPW; k++) begin : g_pin
      localparam int SRC_S = g*PPW + k;
      localparam int SRC_D = g*PPW + (k % PORTS_PER_GPIO)*PORT_WIDTH + k / PORTS_PER_GPIO;
      localparam int PIN_D = g*GPIO_WIDTH + PORTS_PER_GPIO*(k % PORT_WIDTH) + k / PORT_WIDTH;
      assign w_map_out[g*GPIO_WIDTH+k] = w_mode_next[g] ? io_out[SRC_D] : io_out[SRC_S];
      assign w_map_oe[g*GPIO_WIDTH+k]  = w_mode_next[g] ? io_oe[SRC_D]  : io_oe[SRC_S];
      assign w_io_map[g*PPW+k]         = r_mode_cur[g] ? w_in_clean[PIN_D]
                                                       : w_in_clean[g*GPIO_WIDTH+k];
    end
    for (genvar k = PPW; k < GPIO_WIDTH; k++) begin : g_spare
      localparam int SPARE = k - PPW;
      assign w_unused_pins[g*SPW+SPARE] = w_in_clean[g*GPIO_WIDTH+k];
      if (SPARE < LPG) begin : g_led
        assign w_map_out[g*GPIO_WIDTH+k] = w_mode_next[g] & led_out[g*LPG+SPARE];
        assign w_map_oe[g*GPIO_WIDTH+k]  = w_mode_next[g];
      end else begin : g_off
        assign w_map_out[g*GPIO_WIDTH+k] = 1'b0;
        assign w_map_oe[g*GPIO_WIDTH+k]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gpio_out <= '0;
      r_gpio_oe  <= '0;
    end else begin
      r_gpio_out <= w_map_out;
      r_gpio_oe  <= w_oe_allowed ? w_map_oe : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_INPUT_FILTER_EN
  logic [GW-1:0] r_filt1;
  logic [GW-1:0] r_filt2;
  logic [GW-1:0] r_hold;
  logic [GW-1:0] w_stable;

  // A bit follows the synchroniser only once three samples in a row agree.
  assign w_stable   = ~(r_sync2 ^ r_filt1) & ~(r_sync2 ^ r_filt2);
  assign w_in_clean = (w_stable & r_sync2) | (~w_stable & r_hold);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt1 <= '0;
      r_filt2 <= '0;
      r_hold  <= '0;
    end else begin
      r_filt1 <= r_sync2;
      r_filt2 <= r_filt1;
      r_hold  <= w_in_clean;
    end
  end
`else
  assign w_in_clean = r_sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_led_prev <= '0;
    else          r_led_prev <= led_in;
  end

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_stretch
    logic [SCW-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         r_cnt <= '0;
      else if (led_in[i] && !r_led_prev[i]) r_cnt <= STRETCH_LOAD;
      else if (r_cnt != '0)                 r_cnt <= r_cnt - 1'b1;
    end
    assign led_out[i] = (r_cnt != '0);
  end

  assign io_in     = w_io_map;
  assign gpio_out  = r_gpio_out;
  assign gpio_oe   = r_gpio_oe;
  assign mode_cur  = r_mode_cur;
  assign mode_busy = w_busy;

endmodule

// File: tb/tb_gpio_port_mux.sv
// tb_gpio_port_mux: table-driven pin mapping vectors plus hand sequences for mode
// switching, LED stretching (STRETCH_CYCLES scaled to 500), input glitches and reset.
module tb_gpio_port_mux;
  localparam int NG = 2, GWD = 36, PW = 17, PPG = 2, LC = 4, GC = 16, SC = 500;
  localparam int IOW = NG * PPG * PW;
  localparam int GW  = NG * GWD;
`ifdef GPIO_INPUT_FILTER_EN
  localparam int LAT = 4, GLITCH_HIGH = 0, GLITCH_FIRST = -1;
`else
  localparam int LAT = 2, GLITCH_HIGH = 1, GLITCH_FIRST = 2;
`endif

  typedef struct {
    logic [1:0] mode;
    bit         isInput;
    int         src;
    int         exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [IOW-1:0] io_out, io_oe, io_in;
  logic [LC-1:0]  led_in, led_out;
  logic           mode_wr;
  logic [NG-1:0]  mode_req, mode_cur;
  logic           mode_busy;
  logic [GW-1:0]  gpio_out, gpio_oe, gpio_in;

  int testsRun = 0;
  int failCount = 0;
  logic [1:0] curMode = 2'b00;
  vec_t vecs[21];

  gpio_port_mux #(
    .NUM_GPIO(NG), .GPIO_WIDTH(GWD), .PORT_WIDTH(PW), .PORTS_PER_GPIO(PPG),
    .LED_COUNT(LC), .GUARD_CYCLES(GC), .STRETCH_CYCLES(SC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io_out(io_out), .io_oe(io_oe), .io_in(io_in),
    .led_in(led_in), .led_out(led_out), .mode_wr(mode_wr), .mode_req(mode_req),
    .mode_cur(mode_cur), .mode_busy(mode_busy), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [IOW-1:0] ioHot(input int idx);
    logic [IOW-1:0] v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [GW-1:0] pinHot(input int idx);
    logic [GW-1:0] v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // LED pins of a DB25 header are always enabled.
  function automatic logic [GW-1:0] ledMask(input logic [1:0] m);
    logic [GW-1:0] v = '0;
    if (m[0]) v[35:34] = 2'b11;
    if (m[1]) v[71:70] = 2'b11;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic setMode(input logic [1:0] m);
    int n = 0;
    mode_req = m;
    mode_wr  = 1'b1;
    tick();
    mode_wr = 1'b0;
    while (mode_busy && n < 40) begin
      tick();
      n++;
    end
    checkOutput("modeSettle", mode_busy, 1'b0);
    checkOutput("modeApplied", mode_cur, m);
    curMode = m;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    if (v.mode != curMode) setMode(v.mode);
    if (!v.isInput) begin
      io_out = ioHot(v.src);
      io_oe  = ioHot(v.src);
      tick();
      checkOutput($sformatf("vec%0d gpio_out", idx), gpio_out, pinHot(v.exp));
      checkOutput($sformatf("vec%0d gpio_oe", idx), gpio_oe, pinHot(v.exp) | ledMask(v.mode));
      io_out = '0;
      io_oe  = '0;
      tick();
    end else begin
      gpio_in = pinHot(v.src);
      repeat (LAT - 1) tick();
      checkOutput($sformatf("vec%0d io_in early", idx), io_in, '0);
      tick();
      checkOutput($sformatf("vec%0d io_in", idx), io_in, ioHot(v.exp));
      gpio_in = '0;
      repeat (6) tick();
    end
  endtask

  initial begin
    int highCnt, firstHigh, guardOk, ledCnt, pinCnt, otherCnt;

    vecs[0]  = '{2'b00, 1'b0, 5, 5};
    vecs[1]  = '{2'b00, 1'b0, 33, 33};
    vecs[2]  = '{2'b00, 1'b0, 34, 36};
    vecs[3]  = '{2'b00, 1'b0, 67, 69};
    vecs[4]  = '{2'b00, 1'b1, 36, 34};
    vecs[5]  = '{2'b00, 1'b1, 35, -1};
    vecs[6]  = '{2'b00, 1'b1, 3, 3};
    vecs[7]  = '{2'b01, 1'b0, 0, 0};
    vecs[8]  = '{2'b01, 1'b0, 1, 2};
    vecs[9]  = '{2'b01, 1'b0, 16, 32};
    vecs[10] = '{2'b01, 1'b0, 17, 1};
    vecs[11] = '{2'b01, 1'b0, 33, 33};
    vecs[12] = '{2'b01, 1'b0, 34, 36};
    vecs[13] = '{2'b01, 1'b1, 1, 17};
    vecs[14] = '{2'b01, 1'b1, 32, 16};
    vecs[15] = '{2'b01, 1'b1, 34, -1};
    vecs[16] = '{2'b11, 1'b0, 51, 37};
    vecs[17] = '{2'b11, 1'b0, 35, 38};
    vecs[18] = '{2'b11, 1'b0, 67, 69};
    vecs[19] = '{2'b11, 1'b1, 38, 35};
    vecs[20] = '{2'b11, 1'b1, 71, -1};

    reset_n  = 1'b0;
    io_out   = '1;
    io_oe    = '1;
    led_in   = '1;
    gpio_in  = '1;
    mode_wr  = 1'b0;
    mode_req = 2'b11;
    repeat (3) tick();
    checkOutput("reset gpio_out", gpio_out, '0);
    checkOutput("reset gpio_oe", gpio_oe, '0);
    checkOutput("reset io_in", io_in, '0);
    checkOutput("reset led_out", led_out, '0);
    checkOutput("reset mode_cur", mode_cur, 2'b00);
    checkOutput("reset mode_busy", mode_busy, 1'b0);
    io_out = '0; io_oe = '0; led_in = '0; gpio_in = '0; mode_req = 2'b00;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    io_out = ioHot(5);
    io_oe  = ioHot(5);
    checkOutput("out5 before edge", gpio_out[5], 1'b0);
    tick();
    checkOutput("out5", gpio_out[5], 1'b1);
    checkOutput("oe5", gpio_oe[5], 1'b1);
    checkOutput("oe34 straight", gpio_oe[34], 1'b0);
    io_out = '0; io_oe = '0;
    repeat (2) tick();

    highCnt = 0; firstHigh = -1;
    gpio_in = pinHot(3);
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 1) gpio_in = '0;
      if (io_in[3]) begin
        highCnt++;
        if (firstHigh < 0) firstHigh = t;
      end
    end
    checkOutput("glitch high cycles", highCnt, GLITCH_HIGH);
    checkOutput("glitch first high", firstHigh, GLITCH_FIRST);

    highCnt = 0; firstHigh = -1;
    gpio_in = pinHot(3);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 5) gpio_in = '0;
      if (io_in[3]) begin
        highCnt++;
        if (firstHigh < 0) firstHigh = t;
      end
    end
    checkOutput("level first high", firstHigh, LAT);
    checkOutput("level high cycles", highCnt, 5);
    repeat (4) tick();

    for (int i = 0; i < 21; i++) applyStimulus(i, vecs[i]);

    // Full guard sequence 00 -> 01 with enables forced off throughout.
    setMode(2'b00);
    io_out   = ioHot(17);
    io_oe    = '1;
    mode_req = 2'b01;
    mode_wr  = 1'b1;
    tick();
    mode_wr = 1'b0;
    guardOk = 0;
    for (int t = 1; t <= 17; t++) begin
      if (mode_busy === 1'b1 && gpio_oe === '0 && mode_cur === 2'b00) guardOk++;
      tick();
    end
    checkOutput("guard busy/oe cycles", guardOk, 17);
    checkOutput("guard mode_cur applied", mode_cur, 2'b01);
    checkOutput("guard busy cleared", mode_busy, 1'b0);
    checkOutput("db25 port1 bit0 pin1", gpio_out[1], 1'b1);
    checkOutput("db25 pin1 oe", gpio_oe[1], 1'b1);
    checkOutput("db25 led pin oe", gpio_oe[34], 1'b1);
    io_out = '0; io_oe = '0;
    tick();

    // Second write at guard cycle 10 restarts the count.
    mode_req = 2'b10;
    mode_wr  = 1'b1;
    tick();
    mode_wr = 1'b0;
    repeat (9) tick();
    mode_req = 2'b11;
    mode_wr  = 1'b1;
    tick();
    mode_wr = 1'b0;
    repeat (16) tick();
    checkOutput("restart still busy", mode_busy, 1'b1);
    checkOutput("restart mode_cur held", mode_cur, 2'b01);
    tick();
    checkOutput("restart mode_cur", mode_cur, 2'b11);
    checkOutput("restart busy cleared", mode_busy, 1'b0);
    curMode = 2'b11;
    mode_wr = 1'b1;
    tick();
    mode_wr = 1'b0;
    checkOutput("same-mode write ignored", mode_busy, 1'b0);

    ledCnt = 0; pinCnt = 0; otherCnt = 0;
    led_in[0] = 1'b1;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (c == 0) led_in[0] = 1'b0;
      if (led_out[0]) ledCnt++;
      if (gpio_out[34]) pinCnt++;
      if (led_out[1]) otherCnt++;
    end
    checkOutput("led single stretch", ledCnt, SC);
    checkOutput("led pin34 stretch", pinCnt, SC);
    checkOutput("led neighbour quiet", otherCnt, 0);
    checkOutput("led pin34 oe", gpio_oe[34], 1'b1);

    ledCnt = 0;
    led_in[0] = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (c == 0) led_in[0] = 1'b0;
      if (c == 299) led_in[0] = 1'b1;
      if (c == 300) led_in[0] = 1'b0;
      if (led_out[0]) ledCnt++;
    end
    checkOutput("led retrigger stretch", ledCnt, 800);

    // Reset in the middle of a guard period.
    io_out   = '1;
    io_oe    = '1;
    mode_req = 2'b00;
    mode_wr  = 1'b1;
    tick();
    mode_wr = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midguard reset oe", gpio_oe, '0);
    checkOutput("midguard reset out", gpio_out, '0);
    checkOutput("midguard reset busy", mode_busy, 1'b0);
    checkOutput("midguard reset mode_cur", mode_cur, 2'b00);
    io_out = '0; io_oe = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    checkOutput("post-reset mode_cur", mode_cur, 2'b00);
    checkOutput("post-reset busy", mode_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/gpio_port_mux.md
GPIO_PORT_MUX -- requirements
Module: gpio_port_mux

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 2: number of 40-pin expansion headers.
REQ-002 SHALL have parameter GPIO_WIDTH, default 36: pins per header.
REQ-003 SHALL have parameter PORT_WIDTH, default 17: I/O pins per DB25 port.
REQ-004 SHALL have parameter PORTS_PER_GPIO, default 2: ports per header; IOW = NUM_GPIO*PORTS_PER_GPIO*PORT_WIDTH (68 at defaults).
REQ-005 SHALL have parameter LED_COUNT, default 4; LPG = LED_COUNT/NUM_GPIO LEDs per header.
REQ-006 SHALL have parameter GUARD_CYCLES, default 16: tristate guard length on mode change.
REQ-007 SHALL have parameter STRETCH_CYCLES, default 50000: LED pulse-stretch length.
REQ-008 clk  in  1  single clock for all logic.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 io_out  in  IOW  HostMot2 output data.
REQ-011 io_oe  in  IOW  HostMot2 output enables.
REQ-012 io_in  out  IOW  synchronised pin inputs to HostMot2.
REQ-013 led_in  in  LED_COUNT  raw LED activity from HostMot2.
REQ-014 led_out  out  LED_COUNT  stretched LED drive.
REQ-015 mode_wr  in  1  one-cycle strobe to load mode_req.
REQ-016 mode_req  in  NUM_GPIO  per-header adaptor mode, 0=STRAIGHT, 1=DB25.
REQ-017 mode_cur  out  NUM_GPIO  mode currently applied.
REQ-018 mode_busy  out  1  high while a mode change is in progress.
REQ-019 gpio_out, gpio_oe  out  NUM_GPIO*GPIO_WIDTH  header pin data/enables; gpio_in  in  same width  raw header pins.

Function
REQ-020 Header g, pin k, STRAIGHT: k < PORTS_PER_GPIO*PORT_WIDTH SHALL map to io bit g*PORTS_PER_GPIO*PORT_WIDTH+k; remaining pins gpio_oe=0.
REQ-021 Header g, DB25: pin PORTS_PER_GPIO*j+p SHALL map to bit j of port p of header g (port base g*PORTS_PER_GPIO*PORT_WIDTH+p*PORT_WIDTH); remaining pins 0..LPG-1 SHALL drive led_out[g*LPG+i] with oe=1, others oe=0.
REQ-022 Output path (gpio_out, gpio_oe) SHALL be registered: 1-cycle latency from io_out/io_oe.
REQ-023 Input path: each gpio_in bit SHALL pass a 2-flop synchroniser before mapping to io_in; latency 2 cycles (see REQ-035); io_in bits with no mapped pin SHALL be 0.
REQ-024 Mode FSM states IDLE, GUARD, APPLY.
REQ-025 IDLE: mode_wr with mode_req != mode_cur SHALL latch pending and enter GUARD; mode_wr with mode_req == mode_cur SHALL be ignored.
REQ-026 GUARD: all gpio_oe SHALL be 0; counter counts GUARD_CYCLES cycles then enters APPLY.
REQ-027 mode_wr during GUARD SHALL update pending and restart the counter from 0.
REQ-028 APPLY (1 cycle): mode_cur <= pending, return to IDLE; normal mapping resumes the next cycle.
REQ-029 mode_busy SHALL be 1 in GUARD and APPLY, 0 in IDLE.
REQ-030 LED stretcher per bit: rising edge of led_in SHALL load counter with STRETCH_CYCLES; led_out=1 while counter != 0; edge while non-zero SHALL reload (retrigger); counter width = clog2(STRETCH_CYCLES+1).

Reset
REQ-031 reset_n low SHALL asynchronously force: FSM=IDLE, mode_cur=0 (all STRAIGHT), pending=0, mode_busy=0, gpio_out=0, gpio_oe=0, io_in=0, synchroniser/filter flops=0, led_out=0, LED counters=0.
REQ-032 Reset asserted mid-GUARD SHALL abort the change; mode_cur stays 0 after release.
REQ-033 Reset release SHALL be sampled synchronously; first functional edge is the first rising clk after reset_n high.

Configuration
REQ-034 Macro GPIO_INPUT_FILTER_EN SHALL compile in a glitch filter after the synchroniser.
REQ-035 Defined: io_in bit SHALL change only after 3 consecutive equal synchronised samples; latency 4 cycles; pulses shorter than 3 cycles SHALL be rejected. Undefined: no filter, latency 2 cycles, every sampled change passes.

Verification
REQ-036 Reset, STRAIGHT: io_out[5]=1, io_oe[5]=1 -> gpio_out[5]=1, gpio_oe[5]=1 one cycle later; gpio_oe[34]=0.
REQ-037 mode_wr, mode_req=2'b01 -> mode_busy=1, all gpio_oe=0 for 16 cycles, mode_cur=2'b01 at cycle 18; then io_out[17] (port1 bit0) appears on gpio_out[1].
REQ-038 mode_wr at GUARD cycle 10 with mode_req=2'b11 -> counter restarts, mode_cur=2'b11 after 16 further cycles plus APPLY.
REQ-039 DB25 header 0, led_in[0] single-cycle pulse -> led_out[0]=1 and gpio_out[34]=1 for exactly 50000 cycles; second pulse at cycle 30000 -> high until cycle 80000.
REQ-040 gpio_in[3] 1-cycle glitch -> io_in[3] pulses 1 cycle after 2-cycle latency without GPIO_INPUT_FILTER_EN; stays 0 with it; 5-cycle level -> io_in[3]=1 at cycle 4 with filter.
REQ-041 reset_n low at GUARD cycle 8 -> immediately gpio_oe=0, mode_busy=0; after release mode_cur=0.
